// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin write arbiter for an enable-loaded register bank (REG_WR_ARB_FIXED_PRIO_EN selects fixed priority)
module reg_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int N_REG = 4,
  parameter int DW = 8,
  parameter int AW = 2
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] wr_addr,
  input  logic [N_REQ*DW-1:0] wr_data,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REG-1:0]    reg_en,
  output logic [DW-1:0]       reg_d,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic                addr_err
);
  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;
  state_t state, state_n;
  logic [2:0] rr_ptr, win;
  logic found;
  int idx;
  logic [2*N_REQ-1:0] rot;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  // winner search upward from rr_ptr, wrapping, plus next-state selection
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    rot = {req, req} >> rr_ptr;
    for (int i = N_REQ-1; i >= 0; i--)
      if (rot[i]) begin
        idx = int'(rr_ptr) + i;
        win = 3'(idx >= N_REQ ? idx - N_REQ : idx);
        found = 1'b1;
      end
    waddr = wr_addr[win*AW +: AW];
    wdata = wr_data[win*DW +: DW];
    state_n = state == IDLE ? (found ? WRITE : IDLE) : state == WRITE ? ACK : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // registered outputs; the enable is decoded at the latch edge so it lands in the WRITE cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ack <= '0;
      reg_en <= '0;
      reg_d <= '0;
      grant_id <= '0;
      addr_err <= 1'b0;
    end else begin
      ack <= state == WRITE ? N_REQ'(1) << grant_id : '0;
      reg_en <= '0;
      addr_err <= 1'b0;
      if (state == IDLE && found) begin
        grant_id <= win;
        reg_d <= wdata;
        reg_en <= int'(waddr) < N_REG ? N_REG'(1) << waddr : '0;
        addr_err <= int'(waddr) >= N_REG;
      end
    end
  assign busy = state != IDLE;
`ifdef REG_WR_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  // advance the round-robin pointer past the winner once it is acknowledged
  always_ff @(posedge clk or posedge reset)
    if (reset) rr_ptr <= '0;
    else if (state == ACK) rr_ptr <= int'(grant_id) == N_REQ-1 ? '0 : grant_id + 3'd1;
`endif
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb_reg_wr_arbiter: directed self-checking bench for reg_wr_arbiter
module tb_reg_wr_arbiter;
  logic clk, reset;
  logic [3:0] req, ack, reg_en;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0] reg_d;
  logic [2:0] grant_id;
  logic busy, addr_err;
  logic [3:0] req3, ack3;
  logic [7:0] wr_addr3;
  logic [31:0] wr_data3;
  logic [2:0] reg_en3;
  logic [7:0] reg_d3;
  logic [2:0] grant_id3;
  logic busy3, addr_err3;
  logic [7:0] bank [4];
  int checks = 0, errors = 0;
  reg_wr_arbiter u_dut (
    .clk(clk), .reset(reset), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .ack(ack), .reg_en(reg_en), .reg_d(reg_d), .grant_id(grant_id), .busy(busy), .addr_err(addr_err)
  );
  reg_wr_arbiter #(.N_REG(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .ack(ack3), .reg_en(reg_en3), .reg_d(reg_d3), .grant_id(grant_id3), .busy(busy3), .addr_err(addr_err3)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (reset) bank[i] <= '0;
      else if (reg_en[i]) bank[i] <= reg_d;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    req = '0; wr_addr = '0; wr_data = '0;
    req3 = '0; wr_addr3 = '0; wr_data3 = '0;
    tick(); tick();
    chk("rst_out", {ack, reg_en, reg_d, grant_id, busy, addr_err}, '0);
    reset = 1'b0;
    tick();
    req = 4'b0010; wr_addr[2 +: 2] = 2'd2; wr_data[8 +: 8] = 8'hA5;
    tick();
    chk("t2_reg_en", reg_en, 4'b0100);
    chk("t2_reg_d", reg_d, 8'hA5);
    chk("t2_busy_w", busy, 1);
    chk("t2_grant", grant_id, 1);
    tick();
    chk("t2_ack", ack, 4'b0010);
    chk("t2_busy_a", busy, 1);
    chk("t2_bank2", bank[2], 8'hA5);
    chk("t2_en_off", reg_en, 0);
    req = '0;
    tick();
    chk("t2_idle", {busy, ack}, 0);
    req = 4'b1000; wr_addr[6 +: 2] = 2'd3; wr_data[24 +: 8] = 8'h3C;
    tick();
    chk("t4_reg_en", reg_en, 4'b1000);
    wr_data[24 +: 8] = 8'h00;
    tick();
    chk("t4_ack", ack, 4'b1000);
    chk("t4_bank3", bank[3], 8'h3C);
    req = '0;
    tick();
    req = 4'b0001; wr_addr[0 +: 2] = 2'd0; wr_data[0 +: 8] = 8'h11;
    tick();
    chk("t6_wrap_grant", grant_id, 0);
    tick();
    chk("t6_ack0", ack, 4'b0001);
    req = '0;
    tick();
    req = 4'b0101; wr_addr[0 +: 2] = 2'd1; wr_data[0 +: 8] = 8'h22;
    wr_addr[4 +: 2] = 2'd0; wr_data[16 +: 8] = 8'h33;
    tick();
    chk("t6_grant2", grant_id, 2);
    chk("t6_d2", reg_d, 8'h33);
    chk("t6_en2", reg_en, 4'b0001);
    tick();
    chk("t6_ack2", ack, 4'b0100);
    req = 4'b0001;
    tick();
    tick();
    chk("t6_grant0", grant_id, 0);
    chk("t6_en0", reg_en, 4'b0010);
    chk("t6_d0", reg_d, 8'h22);
    tick();
    chk("t6_ack0b", ack, 4'b0001);
    req = '0;
    tick();
    req = 4'b0011;
    tick();
    chk("t6_ptr1", grant_id, 1);
    tick();
    req = '0;
    tick();
    req = 4'b0100; wr_addr[4 +: 2] = 2'd2; wr_data[16 +: 8] = 8'h77;
    tick();
    chk("t1_pre_en", reg_en, 4'b0100);
    #2 reset = 1'b1;
    req = '0;
    #1 chk("t1_async", {ack, reg_en, reg_d, grant_id, busy, addr_err}, '0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_no_ack", {ack, reg_en}, 0);
    end
    req = 4'b1111; wr_addr = 8'b11_10_01_00; wr_data = 32'h43424140;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("t3_rr_ack", ack, (i % 3 == 2) ? 32'(1) << ((i / 3) % 4) : 0);
    end
    req = '0;
    tick(); tick();
    req3 = 4'b0001; wr_addr3[0 +: 2] = 2'd3; wr_data3[0 +: 8] = 8'h55;
    tick();
    chk("t5_err", addr_err3, 1);
    chk("t5_en", reg_en3, 0);
    chk("t5_busy", busy3, 1);
    tick();
    chk("t5_ack", ack3, 4'b0001);
    chk("t5_err_off", addr_err3, 0);
    req3 = '0;
    tick();
    req3 = 4'b0010; wr_addr3[2 +: 2] = 2'd2; wr_data3[8 +: 8] = 8'h66;
    tick();
    chk("t5_ok_en", reg_en3, 3'b100);
    chk("t5_ok_err", addr_err3, 0);
    req3 = '0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Shares one bank of N_REG enable-loaded DW-bit registers (synchronous-reset, enable-gated register type) among N_REQ requesters.
- Arbitrates write requests round-robin and latches the winner's address and data.
- Drives exactly one register enable for one cycle, then acknowledges the winner.
- Sits between requester logic and the register bank. The bank's d inputs are tied to reg_d, and each register's en is tied to its reg_en bit.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- N_REG, 4, number of registers in the bank
- DW, 8, register data width
- AW, 2, register address width; requires 2**AW >= N_REG

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester write request; level, held until ack
- wr_addr  in  N_REQ*AW  packed addresses; requester i at [i*AW +: AW]
- wr_data  in  N_REQ*DW  packed data; requester i at [i*DW +: DW]
- ack  out  N_REQ  one-hot, one-cycle completion pulse to the winner
- reg_en  out  N_REG  one-hot, one-cycle enable to the register bank
- reg_d  out  DW  latched write data to the register bank
- grant_id  out  3  index of the current or last winner
- busy  out  1  high when the FSM is not in IDLE
- addr_err  out  1  one-cycle pulse when the winner's address is >= N_REG

Behaviour:
- Reset (asynchronous, active-high), applied immediately:
  - state = IDLE, rr_ptr = 0
  - ack, reg_en, reg_d, grant_id, busy, addr_err all 0
- Reset mid-operation:
  - aborts the transaction; no reg_en or ack is issued for it
  - after release, any still-pending req is re-arbitrated from rr_ptr = 0
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If req != 0, select a winner w: the first set bit found scanning upward from rr_ptr, wrapping modulo N_REQ.
  - Latch addr_q = wr_addr[w] and reg_d = wr_data[w]; set grant_id = w; go to WRITE.
  - If req == 0, stay in IDLE.
- WRITE (one cycle):
  - If addr_q < N_REG, assert reg_en[addr_q] = 1; the bank captures reg_d on the edge ending this cycle.
  - Otherwise reg_en = 0 and addr_err pulses.
  - Go to ACK.
- ACK (one cycle):
  - ack[w] = 1; set rr_ptr = (w+1) mod N_REQ; go to IDLE.
- Latency:
  - req sampled in IDLE at edge k; reg_en is high in cycle k+1.
  - Register q is visible in cycle k+2, the same cycle as ack.
  - Back-to-back throughput is one write per 3 cycles.
- Requester rule:
  - keep req, wr_addr and wr_data stable until ack is seen
  - drop req on the edge that samples ack
  - if req is still high in the following IDLE cycle, it is a new request, arbitrated with lowest priority
- Input changes after the IDLE-to-WRITE latch edge do not affect the transaction in flight.
- Only one requester is ever served at a time; ack and reg_en are never both high.
- A req that drops before its ack is a protocol violation; the latched write completes regardless.
- grant_id holds its value between transactions.
- rr_ptr wraps from N_REQ-1 to 0.

Optional Feature:
- Macro: REG_WR_ARB_FIXED_PRIO_EN.
- When defined:
  - fixed priority; req[0] is highest and req[N_REQ-1] is lowest
  - rr_ptr is not implemented and is treated as constantly 0
- When undefined: round-robin as described in Behaviour.
- Timing, the handshake and all other outputs are identical in both builds.

Test Plan:
1. Reset asserted asynchronously mid-cycle with the FSM in WRITE and reg_en[2] = 1 -> all outputs are 0 before the next clk edge; after release there is no ack for the aborted write.
2. Only req[1]=1 with wr_addr[1]=2 and wr_data[1]=8'hA5 -> reg_en=4'b0100 and reg_d=8'hA5 one cycle after sampling; ack=4'b0010 the next cycle; busy high for 2 cycles.
3. req=4'b1111 held and re-asserted continuously -> acks follow the order 0,1,2,3,0 (fixed-priority build: 0,0,0,...); one ack every 3 cycles.
4. req[3] with wr_addr[3]=3, and wr_data[3] changed to 8'h00 after the latch edge -> the bank captures the original value 8'h3C at address 3.
5. N_REG=3 and the winner's address is 3 -> addr_err pulses in the WRITE cycle, reg_en stays 0, and ack is still issued the next cycle.
6. req[0] and req[2] asserted together with rr_ptr=1 -> req[2] wins first and req[0] wins second; rr_ptr ends at 1.
